// File: rtl/object_draw_scheduler_if.sv
// Object/pixel bundle between the movers, the draw scheduler and the vga_adapter.
// master = scheduler side, slave = movers/adapter side.
interface object_draw_scheduler_if #(
   parameter int NUM_OBJ = 4
);
   logic [NUM_OBJ*8-1:0] obj_x;
   logic [NUM_OBJ*7-1:0] obj_y;
   logic [NUM_OBJ*3-1:0] obj_colour;
   logic [NUM_OBJ-1:0]   obj_en;
   logic [7:0]           x;
   logic [6:0]           y;
   logic [2:0]           colour;
   logic                 plot;
   logic                 update;
   logic                 busy;
   logic                 collide;

   modport master (
      input  obj_x, obj_y, obj_colour, obj_en,
      output x, y, colour, plot, update, busy, collide
   );

   modport slave (
      output obj_x, obj_y, obj_colour, obj_en,
      input  x, y, colour, plot, update, busy, collide
   );
endinterface

// File: rtl/object_draw_scheduler.sv
// Frame sequencer sharing one vga_adapter write port among NUM_OBJ square sprites.
// Define COLLISION_DETECT_EN to build the slot-0 overlap detector driving collide.
//
// state  | meaning
// WAIT   | count frame ticks until the next move
// ERASE  | paint every latched enabled box black at its last-drawn position
// UPDATE | one-cycle update pulse to the movers
// SETTLE | idle cycle while the movers' registered outputs settle
// LATCH  | capture coordinates, colours and enables into shadow registers
// DRAW   | paint every latched enabled box in its colour
module object_draw_scheduler #(
   parameter int NUM_OBJ     = 4,
   parameter int BOX_LOG2    = 2,
   parameter int FRAME_DIV   = 833333,
   parameter int MOVE_FRAMES = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   object_draw_scheduler_if.master        bus
);
   localparam int SLOT_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam int PIX_W  = 2 * BOX_LOG2;
   localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [PIX_W-1:0]  PIX_LAST   = '1;
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_OBJ - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(FRAME_DIV - 1);
   localparam logic [5:0]        FRAME_LAST = 6'(MOVE_FRAMES - 1);

   typedef enum logic [2:0] {
      S_WAIT, S_ERASE, S_UPDATE, S_SETTLE, S_LATCH, S_DRAW
   } state_t;

   state_t            state, state_n;
   logic [SLOT_W-1:0] slot, slot_n;
   logic [PIX_W-1:0]  pix, pix_n;
   logic [DIV_W-1:0]  delay, delay_n;
   logic [5:0]        frame, frame_n;

   logic [7:0]         sx   [NUM_OBJ];
   logic [6:0]         sy   [NUM_OBJ];
   logic [2:0]         scol [NUM_OBJ];
   logic [NUM_OBJ-1:0] sen;

   logic       walking;
   logic [8:0] px_sum;
   logic [7:0] py_sum;
   logic       pix_vis;

   always_comb begin
      state_n = state;
      slot_n  = slot;
      pix_n   = pix;
      delay_n = delay;
      frame_n = frame;
      case (state)
         S_WAIT: begin
            if (delay == DIV_LAST) begin
               delay_n = '0;
               if (frame == FRAME_LAST) begin
                  frame_n = '0;
                  slot_n  = '0;
                  pix_n   = '0;
                  state_n = S_ERASE;
               end else begin
                  frame_n = frame + 6'd1;
               end
            end else begin
               delay_n = delay + 1'b1;
            end
         end
         S_ERASE, S_DRAW: begin
            // Disabled slots take a single cycle; enabled slots walk all pixels.
            if (sen[slot] && (pix != PIX_LAST)) begin
               pix_n = pix + 1'b1;
            end else begin
               pix_n = '0;
               if (slot == SLOT_LAST) begin
                  slot_n  = '0;
                  state_n = (state == S_ERASE) ? S_UPDATE : S_WAIT;
               end else begin
                  slot_n = slot + 1'b1;
               end
            end
         end
         S_UPDATE: state_n = S_SETTLE;
         S_SETTLE: state_n = S_LATCH;
         S_LATCH: begin
            slot_n  = '0;
            pix_n   = '0;
            state_n = S_DRAW;
         end
         default: state_n = S_LATCH;
      endcase
   end

   // Sums are one bit wider than the screen coordinates so off-screen pixels clip, never wrap.
   assign walking = (state == S_ERASE) || (state == S_DRAW);
   assign px_sum  = {1'b0, sx[slot]} + 9'(pix[BOX_LOG2-1:0]);
   assign py_sum  = {1'b0, sy[slot]} + 8'(pix[PIX_W-1:BOX_LOG2]);
   assign pix_vis = walking && sen[slot] && (px_sum < 9'd160) && (py_sum < 8'd120);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_LATCH;
         slot       <= '0;
         pix        <= '0;
         delay      <= '0;
         frame      <= '0;
         sen        <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            sx[i]   <= '0;
            sy[i]   <= '0;
            scol[i] <= '0;
         end
         bus.x      <= '0;
         bus.y      <= '0;
         bus.colour <= '0;
         bus.plot   <= 1'b0;
         bus.update <= 1'b0;
         bus.busy   <= 1'b0;
      end else begin
         state <= state_n;
         slot  <= slot_n;
         pix   <= pix_n;
         delay <= delay_n;
         frame <= frame_n;
         if (state == S_LATCH) begin
            sen <= bus.obj_en;
            for (int i = 0; i < NUM_OBJ; i++) begin
               sx[i]   <= bus.obj_x[8*i +: 8];
               sy[i]   <= bus.obj_y[7*i +: 7];
               scol[i] <= bus.obj_colour[3*i +: 3];
            end
         end
         bus.plot   <= pix_vis;
         bus.update <= (state == S_UPDATE);
         bus.busy   <= (state != S_WAIT);
         if (walking) begin
            bus.x      <= px_sum[7:0];
            bus.y      <= py_sum[6:0];
            bus.colour <= (state == S_DRAW) ? scol[slot] : 3'b000;
         end
      end
   end

`ifdef COLLISION_DETECT_EN
   localparam logic [8:0] BOX_X = 9'(1 << BOX_LOG2);
   localparam logic [7:0] BOX_Y = 8'(1 << BOX_LOG2);

   logic       hit;
   logic [8:0] ax, bx;
   logic [7:0] ay, by;

   // Overlap against the incoming coordinates, i.e. the positions about to be drawn.
   always_comb begin
      hit = 1'b0;
      ax  = {1'b0, bus.obj_x[7:0]};
      ay  = {1'b0, bus.obj_y[6:0]};
      bx  = '0;
      by  = '0;
      for (int i = 1; i < NUM_OBJ; i++) begin
         bx = {1'b0, bus.obj_x[8*i +: 8]};
         by = {1'b0, bus.obj_y[7*i +: 7]};
         if (bus.obj_en[0] && bus.obj_en[i] &&
             (ax < bx + BOX_X) && (bx < ax + BOX_X) &&
             (ay < by + BOX_Y) && (by < ay + BOX_Y))
            hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         bus.collide <= 1'b0;
      else if (state == S_LATCH)
         bus.collide <= hit;
   end
`else
   assign bus.collide = 1'b0;
`endif

endmodule

// File: tb/tb_object_draw_scheduler.sv
// Scoreboard bench for object_draw_scheduler: expected pixel stream queued from a box model,
// frame timing checked per scenario.
`timescale 1ns/1ps
module tb_object_draw_scheduler;
   localparam int NUM_OBJ = 2, BOX_LOG2 = 2, FRAME_DIV = 4, MOVE_FRAMES = 2;
`ifdef COLLISION_DETECT_EN
   localparam bit COLL = 1'b1;
`else
   localparam bit COLL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   object_draw_scheduler_if #(.NUM_OBJ(NUM_OBJ)) bus ();

   object_draw_scheduler #(
      .NUM_OBJ(NUM_OBJ), .BOX_LOG2(BOX_LOG2),
      .FRAME_DIV(FRAME_DIV), .MOVE_FRAMES(MOVE_FRAMES)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
   pix_t exp_q[$];
   pix_t mon_e;
   int   m_x[NUM_OBJ], m_y[NUM_OBJ];
   bit   m_en[NUM_OBJ];
   string nm[6] = '{"wait_cycles", "erase_cycles", "erase_plots", "update_width", "draw_cycles", "draw_plots"};

   always @(negedge clk) begin
      if (bus.plot === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pixel_extra: got (%0d,%0d,c%0d) required no plot", bus.x, bus.y, bus.colour);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.x, bus.y, bus.colour} !== {mon_e.x, mon_e.y, mon_e.c}) begin
               n_err++;
               $display("FAIL pixel: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                        bus.x, bus.y, bus.colour, mon_e.x, mon_e.y, mon_e.c);
            end
         end
      end
   end

   task automatic push_box(input int bx, input int by, input int c, input int npix);
      pix_t e;
      for (int p = 0; p < npix; p++) begin
         int px = bx + (p % 4);
         int py = by + (p / 4);
         if (px < 160 && py < 120) begin
            e.x = 8'(px); e.y = 7'(py); e.c = 3'(c);
            exp_q.push_back(e);
         end
      end
   endtask

   // Drives the next frame's inputs and queues its expected erase and draw pixels.
   task automatic load_frame(input bit erase, input bit draw,
                             input int x0, input int y0, input int c0,
                             input int x1, input int y1, input int c1, input logic [1:0] en);
      int nx[2] = '{x0, x1};
      int ny[2] = '{y0, y1};
      int nc[2] = '{c0, c1};
      bus.obj_x      = {8'(x1), 8'(x0)};
      bus.obj_y      = {7'(y1), 7'(y0)};
      bus.obj_colour = {3'(c1), 3'(c0)};
      bus.obj_en     = en;
      if (erase)
         for (int i = 0; i < NUM_OBJ; i++) if (m_en[i]) push_box(m_x[i], m_y[i], 0, 16);
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (draw && en[i]) push_box(nx[i], ny[i], nc[i], 16);
         m_x[i] = nx[i]; m_y[i] = ny[i]; m_en[i] = en[i];
      end
   endtask

   // Called at the negedge where busy has just dropped; returns at the next such negedge.
   task automatic measure_frame(output int r[6], output bit to);
      int g = 0;
      for (int i = 0; i < 6; i++) r[i] = 0;
      while (bus.busy !== 1'b1 && g < 300) begin r[0]++; g++; @(negedge clk); end
      while (bus.busy === 1'b1 && bus.update !== 1'b1 && g < 300) begin
         r[1]++; if (bus.plot === 1'b1) r[2]++; g++; @(negedge clk);
      end
      while (bus.update === 1'b1 && g < 300) begin r[3]++; g++; @(negedge clk); end
      while (bus.busy === 1'b1 && g < 300) begin
         r[4]++; if (bus.plot === 1'b1) r[5]++; g++; @(negedge clk);
      end
      r[4] -= 2;
      to = (g >= 300);
   endtask

   task automatic measure_first(output int pre, output int busy_c, output int plots,
                                output int upd, output bit to);
      int g = 0;
      pre = 0; busy_c = 0; plots = 0; upd = 0;
      @(negedge clk);
      while (bus.busy !== 1'b1 && g < 300) begin pre++; g++; @(negedge clk); end
      while (bus.busy === 1'b1 && g < 300) begin
         busy_c++;
         if (bus.plot === 1'b1) plots++;
         if (bus.update === 1'b1) upd++;
         g++; @(negedge clk);
      end
      to = (g >= 300);
   endtask

   task automatic check_frame(input string tag, input int r[6], input int req[6], input bit to);
      n_cmp++;
      if (to) begin n_err++; $display("FAIL %s_timeout: got timeout required frame end", tag); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (r[i] !== req[i]) begin
            n_err++; $display("FAIL %s_%s: got %0d required %0d", tag, nm[i], r[i], req[i]);
         end
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++; $display("FAIL %s_pixels_missing: got %0d left required 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset();
      bus.obj_x = '0; bus.obj_y = '0; bus.obj_colour = '0; bus.obj_en = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.x, bus.y, bus.colour, bus.plot, bus.update, bus.busy, bus.collide} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got x%0d y%0d c%0d p%0b u%0b b%0b k%0b required all 0",
                  bus.x, bus.y, bus.colour, bus.plot, bus.update, bus.busy, bus.collide);
      end
   endtask

   task automatic test_first_draw();
      int pre, bc, pl, up; bit to;
      load_frame(1'b0, 1'b1, 10, 20, 7, 50, 60, 4, 2'b11);
      reset = 1'b0;
      measure_first(pre, bc, pl, up, to);
      n_cmp++; if (to)      begin n_err++; $display("FAIL first_timeout: got timeout required busy drop"); end
      n_cmp++; if (pre !== 0) begin n_err++; $display("FAIL first_pre_idle: got %0d required 0", pre); end
      n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL first_busy_cycles: got %0d required 33", bc); end
      n_cmp++; if (pl !== 32) begin n_err++; $display("FAIL first_plots: got %0d required 32", pl); end
      n_cmp++; if (up !== 0)  begin n_err++; $display("FAIL first_update: got %0d required 0", up); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL first_busy_end: got %0b required 0", bus.busy); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL first_pixels_missing: got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_frame_period();
      int r[6]; bit to;
      load_frame(1'b1, 1'b1, 30, 40, 7, 70, 80, 2, 2'b11);
      measure_frame(r, to);
      check_frame("period", r, '{8, 32, 32, 1, 32, 32}, to);
   endtask

   task automatic test_clipping();
      int r[6]; bit to;
      load_frame(1'b1, 1'b1, 30, 40, 7, 158, 60, 4, 2'b11);
      measure_frame(r, to);
      check_frame("clip", r, '{8, 32, 32, 1, 32, 24}, to);
   endtask

   task automatic test_disabled_slot();
      int r[6]; bit to;
      load_frame(1'b1, 1'b1, 60, 50, 3, 90, 10, 5, 2'b01);
      fork
         measure_frame(r, to);
         begin
            int g = 0;
            while (bus.update !== 1'b1 && g < 300) begin @(negedge clk); g++; end
            repeat (6) @(negedge clk);
            bus.obj_x = {8'd100, 8'd5};
         end
      join
      check_frame("disabled", r, '{8, 32, 24, 1, 17, 16}, to);
   endtask

   task automatic test_collision();
      int r[6]; bit to;
      load_frame(1'b1, 1'b1, 10, 20, 7, 13, 23, 4, 2'b11);
      measure_frame(r, to);
      check_frame("coll_hit", r, '{8, 17, 16, 1, 32, 32}, to);
      n_cmp++;
      if (bus.collide !== COLL) begin n_err++; $display("FAIL collide_hit: got %0b required %0b", bus.collide, COLL); end
      load_frame(1'b1, 1'b1, 10, 20, 7, 14, 20, 4, 2'b11);
      measure_frame(r, to);
      check_frame("coll_miss", r, '{8, 32, 32, 1, 32, 32}, to);
      n_cmp++;
      if (bus.collide !== 1'b0) begin n_err++; $display("FAIL collide_clear: got %0b required 0", bus.collide); end
   endtask

   task automatic test_reset_mid_draw();
      int g = 0, n = 0, pre, bc, pl, up; bit to;
      load_frame(1'b1, 1'b0, 80, 90, 5, 20, 30, 6, 2'b11);
      push_box(80, 90, 5, 8);
      while (bus.update !== 1'b1 && g < 300) begin @(negedge clk); g++; end
      while (n < 8 && g < 300) begin
         @(negedge clk); g++;
         if (bus.plot === 1'b1) n++;
      end
      n_cmp++; if (g >= 300) begin n_err++; $display("FAIL midreset_timeout: got %0d plots required 8", n); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.plot !== 1'b0) begin n_err++; $display("FAIL midreset_plot: got %0b required 0", bus.plot); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %0b required 0", bus.busy); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL midreset_pixels_missing: got %0d required 0", exp_q.size()); end
      @(negedge clk);
      push_box(80, 90, 5, 16);
      push_box(20, 30, 6, 16);
      reset = 1'b0;
      measure_first(pre, bc, pl, up, to);
      n_cmp++; if (to)      begin n_err++; $display("FAIL redraw_timeout: got timeout required busy drop"); end
      n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL redraw_busy_cycles: got %0d required 33", bc); end
      n_cmp++; if (pl !== 32) begin n_err++; $display("FAIL redraw_plots: got %0d required 32", pl); end
      n_cmp++; if (up !== 0)  begin n_err++; $display("FAIL redraw_update: got %0d required 0", up); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL redraw_pixels_missing: got %0d required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_frame_period();
      test_clipping();
      test_disabled_slot();
      test_collision();
      test_reset_mid_draw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
